ysyx_22040895_mem_arb: RTL and testbench

//  Shares the single memory port between instruction fetch (IF, read-only) and the load/store unit (LS, read/write).

---
 rtl/ysyx_22040895_mem_arb.sv | 205 ++++++++++++++++++++
 tb/tb_ysyx_22040895_mem_arb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040895_mem_arb.sv
// Memory-port arbiter: shares one memory request/response port between instruction fetch (IF)
// and load/store (LS), one transaction at a time. Define ARB_RR_EN for round-robin, else LS wins.
module ysyx_22040895_mem_arb #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  // instruction fetch side (read-only)
  input  logic            if_valid_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_ready_o,
  output logic            if_rvalid_o,
  output logic [DW-1:0]   if_rdata_o,
  output logic            if_err_o,
  // load/store side
  input  logic            ls_valid_i,
  input  logic            ls_wen_i,
  input  logic [AW-1:0]   ls_addr_i,
  input  logic [DW-1:0]   ls_wdata_i,
  input  logic [DW/8-1:0] ls_wmask_i,
  output logic            ls_ready_o,
  output logic            ls_rvalid_o,
  output logic [DW-1:0]   ls_rdata_o,
  output logic            ls_err_o,
  // memory bus wrapper side
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic            mem_wen_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_wmask_o,
  input  logic            mem_rvalid_i,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic            busy_o
);

  localparam int MW = DW / 8;
  localparam int CW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q;
  logic            wen_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [MW-1:0]   wmask_q;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            if_rvalid_q, ls_rvalid_q, if_err_q, ls_err_q;
  logic [DW-1:0]   if_rdata_q, ls_rdata_q;

  logic            grant_if, grant_ls, accept;
  logic            in_txn, to_hit, done_ok, done_err, rsp_fire;
  logic [DW-1:0]   rsp_data;

  // ---------------------------------------------------------------- arbitration
`ifdef ARB_RR_EN
  logic last_ls_q;  // 1 = LS was granted last

  always_comb begin
    grant_ls = ls_valid_i && (!if_valid_i || !last_ls_q);
    grant_if = if_valid_i && !grant_ls;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ls_q <= 1'b1;
    end else if (accept) begin
      last_ls_q <= grant_ls;
    end
  end
`else
  always_comb begin
    grant_ls = ls_valid_i;
    grant_if = if_valid_i && !ls_valid_i;
  end
`endif

  assign accept = (state_q == S_IDLE) && (grant_if || grant_ls);

  // ---------------------------------------------------------------- completion
  assign in_txn   = (state_q == S_REQ) || (state_q == S_RSP);
  assign to_hit   = TO_EN && in_txn && (cnt_q == TO_LAST);
  // A memory response arriving on the deadline cycle still counts as a normal completion.
  assign done_ok  = (state_q == S_RSP) && mem_rvalid_i;
  assign done_err = to_hit && !done_ok;
  assign rsp_fire = done_ok || done_err;
  assign rsp_data = (done_ok && !wen_q) ? mem_rdata_i : '0;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (in_txn) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_REQ;
      S_REQ: begin
        if (to_hit) begin
          state_d = S_IDLE;
        end else if (mem_ready_i) begin
          state_d = S_RSP;
        end
      end
      S_RSP:   if (rsp_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  // NOTE: every output gets a default before any condition, so no path infers a latch.
  always_comb begin
    if_ready_o  = 1'b0;
    ls_ready_o  = 1'b0;
    mem_valid_o = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    busy_o      = (state_q != S_IDLE);
    // Readies are combinational; qualify with rst so they read 0 while reset is held.
    if (rst && state_q == S_IDLE) begin
      if_ready_o = grant_if;
      ls_ready_o = grant_ls;
    end
    if (state_q == S_REQ) begin
      mem_valid_o = 1'b1;
      mem_wen_o   = wen_q;
      mem_addr_o  = addr_q;
      mem_wdata_o = wdata_q;
      mem_wmask_o = wmask_q;
    end
  end

  // ---------------------------------------------------------------- request latch, counter, responses
  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the request latch is reset as well: it is a handful of flops, not a memory array.
      owner_q     <= OWN_NONE;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt_q       <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      ls_err_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        owner_q <= grant_ls ? OWN_LS : OWN_IF;
        wen_q   <= grant_ls && ls_wen_i;
        addr_q  <= grant_ls ? ls_addr_i : if_addr_i;
        wdata_q <= grant_ls ? ls_wdata_i : '0;
        wmask_q <= grant_ls ? ls_wmask_i : '0;
      end else if (rsp_fire) begin
        owner_q <= OWN_NONE;
      end

      if_rvalid_q <= rsp_fire && (owner_q == OWN_IF);
      ls_rvalid_q <= rsp_fire && (owner_q == OWN_LS);
      if (rsp_fire && owner_q == OWN_IF) begin
        if_rdata_q <= rsp_data;
        if_err_q   <= done_err;
      end
      if (rsp_fire && owner_q == OWN_LS) begin
        ls_rdata_q <= rsp_data;
        ls_err_q   <= done_err;
      end
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_err_o    = if_err_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign ls_err_o    = ls_err_q;

endmodule

// File: tb/tb_ysyx_22040895_mem_arb.sv
// Scoreboard bench for ysyx_22040895_mem_arb: stimulus pushes expected memory requests and
// responses (with expected cycle); a negedge monitor pops and compares. Honours ARB_RR_EN.
module tb_ysyx_22040895_mem_arb;

  localparam int TO = 8;  // long enough for the 5-cycle stall case, short enough to test

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_ready_o, if_rvalid_o, if_err_o;
  logic [31:0] if_rdata_o;
  logic        ls_valid_i = 1'b0;
  logic        ls_wen_i = 1'b0;
  logic [31:0] ls_addr_i = '0;
  logic [31:0] ls_wdata_i = '0;
  logic [3:0]  ls_wmask_i = '0;
  logic        ls_ready_o, ls_rvalid_o, ls_err_o;
  logic [31:0] ls_rdata_o;
  logic        mem_valid_o, mem_wen_o, busy_o;
  logic        mem_ready_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_rdata_i = '0;

  ysyx_22040895_mem_arb #(.AW(32), .DW(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_valid_i(ls_valid_i), .ls_wen_i(ls_wen_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i), .ls_ready_o(ls_ready_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_wen_o(mem_wen_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic wen; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wmask; } req_t;
  typedef struct { logic is_ls; logic err; logic [31:0] data; int at; } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask);
    req_t r;
    r.wen = wen; r.addr = addr; r.wdata = wdata; r.wmask = wmask;
    req_q.push_back(r);
  endtask

  task automatic exp_rsp(input logic is_ls, input logic err, input logic [31:0] data, input int at);
    rsp_t r;
    r.is_ls = is_ls; r.err = err; r.data = data; r.at = at;
    rsp_q.push_back(r);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {if_ready_o, if_rvalid_o, if_err_o, ls_ready_o, ls_rvalid_o, ls_err_o,
                          mem_valid_o, mem_wen_o, mem_wmask_o, busy_o}, 64'd0);
    check({tag, "_if_rdata"}, if_rdata_o, 64'd0);
    check({tag, "_ls_rdata"}, ls_rdata_o, 64'd0);
    check({tag, "_mem_addr"}, mem_addr_o, 64'd0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 64'd0);
  endtask

  // Memory side of a granted transaction; entered in C1 (just after the grant edge).
  task automatic mem_serve(input int stall, input logic [31:0] rdata, input logic [31:0] addr);
    repeat (stall) begin
      @(negedge clk);
      check("stall_mem_valid", mem_valid_o, 64'd1);
      check("stall_mem_addr", mem_addr_o, addr);
      tick();
    end
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  // ---------------------------------------------------------------- monitor
  req_t mr;
  rsp_t ms;
  always @(negedge clk) begin
    if (rst) begin
      if (mem_valid_o && mem_ready_i) begin
        if (req_q.size() == 0) begin
          check("spurious_mem_req", mem_valid_o, 64'd0);
        end else begin
          mr = req_q.pop_front();
          check("req_wen", mem_wen_o, mr.wen);
          check("req_addr", mem_addr_o, mr.addr);
          check("req_wdata", mem_wdata_o, mr.wdata);
          check("req_wmask", mem_wmask_o, mr.wmask);
        end
      end
      if (if_rvalid_o || ls_rvalid_o) begin
        if (rsp_q.size() == 0) begin
          check("spurious_rsp", {if_rvalid_o, ls_rvalid_o}, 64'd0);
        end else begin
          ms = rsp_q.pop_front();
          check("rsp_owner", {ls_rvalid_o, if_rvalid_o}, ms.is_ls ? 64'd2 : 64'd1);
          check("rsp_cycle", cyc, ms.at);
          check("rsp_err", ms.is_ls ? ls_err_o : if_err_o, ms.err);
          check("rsp_data", ms.is_ls ? ls_rdata_o : if_rdata_o, ms.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  int  c0;
  logic exp_ls;
  initial begin
    // Reset with both requesters asserting: readies must still read 0.
    if_valid_i = 1'b1;
    ls_valid_i = 1'b1;
    #1 rst = 1'b0;
    #1 check_all_zero("reset");
    if_valid_i = 1'b0;
    ls_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // IF read: grant C0, response C3 with 0x13.
    if_valid_i = 1'b1;
    if_addr_i  = 32'h8000_0000;
    @(negedge clk);
    check("t1_if_ready", if_ready_o, 64'd1);
    check("t1_ls_ready", ls_ready_o, 64'd0);
    check("t1_busy_idle", busy_o, 64'd0);
    c0 = cyc;
    exp_req(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    exp_rsp(1'b0, 1'b0, 32'h0000_0013, c0 + 3);
    tick();
    if_valid_i = 1'b0;
    mem_serve(0, 32'h0000_0013, 32'h8000_0000);
    @(negedge clk);
    check("t1_busy_after", busy_o, 64'd0);
    tick();

    // Both valid: LS write wins; IF (held) granted right after LS response.
    if_valid_i = 1'b1;
    if_addr_i  = 32'h8000_0004;
    ls_valid_i = 1'b1;
    ls_wen_i   = 1'b1;
    ls_addr_i  = 32'h8000_0100;
    ls_wdata_i = 32'hDEAD_BEEF;
    ls_wmask_i = 4'hF;
    @(negedge clk);
    check("t2_ls_ready", ls_ready_o, 64'd1);
    check("t2_if_ready", if_ready_o, 64'd0);
    c0 = cyc;
    exp_req(1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'hF);
    exp_rsp(1'b1, 1'b0, 32'h0, c0 + 3);  // write ack carries rdata 0
    tick();
    ls_valid_i = 1'b0;
    @(negedge clk);
    check("t2_if_wait_busy", if_ready_o, 64'd0);
    mem_serve(0, 32'h1234_5678, 32'h8000_0100);
    @(negedge clk);
    check("t2_if_granted", if_ready_o, 64'd1);
    c0 = cyc;
    exp_req(1'b0, 32'h8000_0004, 32'h0, 4'h0);
    exp_rsp(1'b0, 1'b0, 32'hA5A5_0001, c0 + 3);
    tick();
    if_valid_i = 1'b0;
    mem_serve(0, 32'hA5A5_0001, 32'h8000_0004);
    tick();

    // LS read with mem_ready_i low for 5 cycles.
    ls_valid_i = 1'b1;
    ls_wen_i   = 1'b0;
    ls_addr_i  = 32'h8000_0200;
    ls_wmask_i = 4'h0;
    @(negedge clk);
    check("t3_ls_ready", ls_ready_o, 64'd1);
    c0 = cyc;
    exp_req(1'b0, 32'h8000_0200, 32'hDEAD_BEEF, 4'h0);
    exp_rsp(1'b1, 1'b0, 32'hCAFE_F00D, c0 + 3 + 5);
    tick();
    ls_valid_i = 1'b0;
    mem_serve(5, 32'hCAFE_F00D, 32'h8000_0200);
    tick();

    // Timeout: IF read, memory never answers; error TO cycles after leaving IDLE.
    if_valid_i = 1'b1;
    if_addr_i  = 32'h8000_0300;
    @(negedge clk);
    check("t4_if_ready", if_ready_o, 64'd1);
    c0 = cyc;
    exp_rsp(1'b0, 1'b1, 32'h0, c0 + 1 + TO);
    tick();
    if_valid_i = 1'b0;
    @(negedge clk);
    check("t4_mem_valid", mem_valid_o, 64'd1);
    repeat (TO) tick();
    @(negedge clk);
    check("t4_busy_after_to", busy_o, 64'd0);
    // Late response and stray ready while idle must be ignored.
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFF_FFFF;
    mem_ready_i  = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_ready_i  = 1'b0;
    @(negedge clk);
    check("t4_late_no_rvalid", {if_rvalid_o, ls_rvalid_o}, 64'd0);
    check("t4_late_rdata_held", if_rdata_o, 64'd0);
    check("t4_late_busy", busy_o, 64'd0);

    // Arbitration pattern with both requesting continuously, from a fresh reset.
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    if_valid_i = 1'b1;
    if_addr_i  = 32'h8000_1000;
    ls_valid_i = 1'b1;
    ls_wen_i   = 1'b0;
    ls_addr_i  = 32'h8000_2000;
    ls_wdata_i = 32'h0;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp_ls = (k % 2 == 1);
`else
      exp_ls = 1'b1;
`endif
      @(negedge clk);
      check("t5_grant_ls", ls_ready_o, exp_ls);
      check("t5_grant_if", if_ready_o, !exp_ls);
      c0 = cyc;
      exp_req(1'b0, exp_ls ? 32'h8000_2000 : 32'h8000_1000, 32'h0, 4'h0);
      exp_rsp(exp_ls, 1'b0, 32'h100 + k, c0 + 3);
      tick();
      mem_serve(0, 32'h100 + k, exp_ls ? 32'h8000_2000 : 32'h8000_1000);
    end
    if_valid_i = 1'b0;
    ls_valid_i = 1'b0;
    tick();

    // Reset during RSP: everything clears, no response pulse afterwards.
    ls_valid_i = 1'b1;
    ls_addr_i  = 32'h8000_0400;
    @(negedge clk);
    check("t6_ls_ready", ls_ready_o, 64'd1);
    exp_req(1'b0, 32'h8000_0400, 32'h0, 4'h0);
    tick();
    ls_valid_i  = 1'b0;
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    check("t6_busy_in_rsp", busy_o, 64'd1);
    #2 rst = 1'b0;
    #1 check_all_zero("t6_async_rst");
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h5555_AAAA;
    tick();
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("t6_post_busy", busy_o, 64'd0);
    check("t6_post_rvalid", {if_rvalid_o, ls_rvalid_o}, 64'd0);

    repeat (2) tick();
    check("req_q_drained", req_q.size(), 64'd0);
    check("rsp_q_drained", rsp_q.size(), 64'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
